// File: rtl/cnn_pkg.sv
// Shared types and helpers for the int8 convolution / pooling engine.
package cnn_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMac,
        StReq,
        StPack,
        StWr,
        StDone
    } state_e;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Signed byte from lane 0..3 of a little-endian word.
    function automatic logic signed [7:0] lane_byte(input logic [31:0] word,
                                                   input logic [1:0]  lane);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        return shifted[7:0];
    endfunction

    // Arithmetic shift, then clamp to 0..127 (ReLU plus int8 saturation).
    function automatic logic [6:0] requant(input logic signed [31:0] acc,
                                           input int unsigned        shift);
        logic signed [31:0] r;
        r = acc >>> shift;
        if (r < 0) begin
            return 7'd0;
        end else if (r > 32'sd127) begin
            return 7'd127;
        end
        return r[6:0];
    endfunction

endpackage

// File: rtl/out_packer.sv
// Collects result bytes into a word and owns every BRAM_TEMP drive.
module out_packer #(
    parameter int unsigned OUT_BASE = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    input  logic        last_i,
    input  logic        wr_i,
    output logic        flush_o,
    output logic [31:0] temp_addr_o,
    output logic        temp_en_o,
    output logic [3:0]  temp_we_o,
    output logic        temp_rst_o,
    output logic [31:0] temp_din_o
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] pack_q, pack_d;
    logic [31:0] waddr_q, waddr_d;

    // Next-state for lane counter, pack register and word offset.
    always_comb begin
        lane_d  = lane_q;
        pack_d  = pack_q;
        waddr_d = waddr_q;
        if (clr_i) begin
            lane_d  = '0;
            pack_d  = '0;
            waddr_d = '0;
        end else if (push_i) begin
            pack_d = pack_q | ({24'd0, byte_i} << {lane_q, 3'b000});
            lane_d = lane_q + 2'd1;
        end else if (wr_i) begin
            pack_d  = '0;
            lane_d  = '0;
            waddr_d = waddr_q + 32'd4;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lane_q  <= '0;
            pack_q  <= '0;
            waddr_q <= '0;
        end else begin
            lane_q  <= lane_d;
            pack_q  <= pack_d;
            waddr_q <= waddr_d;
        end
    end

    // A word is flushed once lane 3 fills or the final byte arrives.
    always_comb begin
        flush_o     = push_i && ((lane_q == 2'd3) || last_i);
        temp_en_o   = wr_i;
        temp_we_o   = wr_i ? 4'hF : 4'h0;
        temp_addr_o = wr_i ? (OUT_BASE + waddr_q) : 32'd0;
        temp_din_o  = wr_i ? pack_q : 32'd0;
        temp_rst_o  = 1'b0;
    end

endmodule

// File: rtl/conv_pool_engine.sv
// Parametrised int8 convolution with ReLU, optional 2x2 max-pool and packed int8 output.
module conv_pool_engine
    import cnn_pkg::*;
#(
    parameter int unsigned IN_H     = 32,
    parameter int unsigned IN_W     = 32,
    parameter int unsigned IN_CH    = 1,
    parameter int unsigned OUT_CH   = 6,
    parameter int unsigned K        = 5,
    parameter int unsigned POOL     = 1,
    parameter int unsigned SHIFT    = 8,
    parameter int unsigned IF_BASE  = 0,
    parameter int unsigned W_BASE   = 0,
    parameter int unsigned OUT_BASE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] BRAM_IF_ADDR,
    output logic        BRAM_IF_EN,
    output logic [3:0]  BRAM_IF_WE,
    output logic        BRAM_IF_RST,
    input  logic [31:0] BRAM_IF_DOUT,
    output logic [31:0] BRAM_IF_DIN,
    output logic [31:0] BRAM_W_ADDR,
    output logic        BRAM_W_EN,
    output logic [3:0]  BRAM_W_WE,
    output logic        BRAM_W_RST,
    input  logic [31:0] BRAM_W_DOUT,
    output logic [31:0] BRAM_W_DIN,
    output logic [31:0] BRAM_TEMP_ADDR,
    output logic        BRAM_TEMP_EN,
    output logic [3:0]  BRAM_TEMP_WE,
    output logic        BRAM_TEMP_RST,
    input  logic [31:0] BRAM_TEMP_DOUT,
    output logic [31:0] BRAM_TEMP_DIN
);

    localparam int unsigned OH  = (IN_H - K + 1) >> POOL;
    localparam int unsigned OW  = (IN_W - K + 1) >> POOL;
    localparam int unsigned PS  = (POOL != 0) ? 2 : 1;
    localparam int unsigned OCW = cnt_w(OUT_CH);
    localparam int unsigned OYW = cnt_w(OH);
    localparam int unsigned OXW = cnt_w(OW);
    localparam int unsigned CW  = cnt_w(IN_CH);
    localparam int unsigned KW  = cnt_w(K);

    localparam logic [OCW-1:0] O_MAX  = OCW'(OUT_CH - 1);
    localparam logic [OYW-1:0] OY_MAX = OYW'(OH - 1);
    localparam logic [OXW-1:0] OX_MAX = OXW'(OW - 1);
    localparam logic [CW-1:0]  C_MAX  = CW'(IN_CH - 1);
    localparam logic [KW-1:0]  K_MAX  = KW'(K - 1);

    state_e             state_q, state_d;
    logic [OCW-1:0]     o_q, o_d;
    logic [OYW-1:0]     oy_q, oy_d;
    logic [OXW-1:0]     ox_q, ox_d;
    logic               py_q, py_d, px_q, px_d;
    logic [CW-1:0]      c_q, c_d;
    logic [KW-1:0]      ky_q, ky_d, kx_q, kx_d;
    logic signed [31:0] acc_q, acc_d;
    logic [6:0]         max_q, max_d;
    logic               fin_q, fin_d;
    logic               done_q, done_d;

    logic [31:0]        if_b, w_b;
    logic signed [7:0]  a_byte, w_byte;
    logic signed [15:0] prod;
    logic [6:0]         rq;
    logic               tap_last, out_last;
    logic               pk_clr, pk_push, pk_wr, pk_flush;

    // Byte indices of the current tap, operand lanes and per-tap arithmetic.
    always_comb begin
        if_b = 32'(c_q) * (IN_H * IN_W)
             + (32'(oy_q) * PS + 32'(py_q) + 32'(ky_q)) * IN_W
             + 32'(ox_q) * PS + 32'(px_q) + 32'(kx_q);
        w_b  = ((32'(o_q) * IN_CH + 32'(c_q)) * K + 32'(ky_q)) * K + 32'(kx_q);
        a_byte   = lane_byte(BRAM_IF_DOUT, if_b[1:0]);
        w_byte   = lane_byte(BRAM_W_DOUT, w_b[1:0]);
        prod     = a_byte * w_byte;
        rq       = requant(acc_q, SHIFT);
        tap_last = (kx_q == K_MAX) && (ky_q == K_MAX) && (c_q == C_MAX);
        out_last = (ox_q == OX_MAX) && (oy_q == OY_MAX) && (o_q == O_MAX);
    end

    // Read ports: addresses are only driven while fetching a tap.
    always_comb begin
        BRAM_IF_EN   = (state_q == StLoad);
        BRAM_W_EN    = (state_q == StLoad);
        BRAM_IF_ADDR = BRAM_IF_EN ? (IF_BASE + {if_b[31:2], 2'b00}) : 32'd0;
        BRAM_W_ADDR  = BRAM_W_EN ? (W_BASE + {w_b[31:2], 2'b00}) : 32'd0;
        BRAM_IF_WE   = 4'h0;
        BRAM_W_WE    = 4'h0;
        BRAM_IF_DIN  = 32'd0;
        BRAM_W_DIN   = 32'd0;
        BRAM_IF_RST  = 1'b0;
        BRAM_W_RST   = 1'b0;
        busy         = (state_q != StIdle) && (state_q != StDone);
        done         = done_q;
    end

    // Layer sequencer: next state, index counters, accumulator and pool max.
    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        oy_d    = oy_q;
        ox_d    = ox_q;
        py_d    = py_q;
        px_d    = px_q;
        c_d     = c_q;
        ky_d    = ky_q;
        kx_d    = kx_q;
        acc_d   = acc_q;
        max_d   = max_q;
        fin_d   = fin_q;
        done_d  = done_q;
        pk_clr  = 1'b0;
        pk_push = 1'b0;
        pk_wr   = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    state_d = StLoad;
                    o_d     = '0;
                    oy_d    = '0;
                    ox_d    = '0;
                    py_d    = 1'b0;
                    px_d    = 1'b0;
                    c_d     = '0;
                    ky_d    = '0;
                    kx_d    = '0;
                    acc_d   = '0;
                    max_d   = '0;
                    fin_d   = 1'b0;
                    done_d  = 1'b0;
                    pk_clr  = 1'b1;
                end
            end
            StLoad: state_d = StMac;
            StMac: begin
                acc_d   = acc_q + {{16{prod[15]}}, prod};
                state_d = tap_last ? StReq : StLoad;
                if (kx_q != K_MAX) begin
                    kx_d = kx_q + 1'b1;
                end else begin
                    kx_d = '0;
                    if (ky_q != K_MAX) begin
                        ky_d = ky_q + 1'b1;
                    end else begin
                        ky_d = '0;
                        c_d  = (c_q == C_MAX) ? '0 : c_q + 1'b1;
                    end
                end
            end
            StReq: begin
                acc_d = '0;
                max_d = (rq > max_q) ? rq : max_q;
                if (POOL == 0 || (px_q && py_q)) begin
                    px_d    = 1'b0;
                    py_d    = 1'b0;
                    state_d = StPack;
                end else begin
                    px_d    = ~px_q;
                    py_d    = py_q | px_q;
                    state_d = StLoad;
                end
            end
            StPack: begin
                pk_push = 1'b1;
                max_d   = '0;
                fin_d   = out_last;
                state_d = pk_flush ? StWr : StLoad;
                if (ox_q != OX_MAX) begin
                    ox_d = ox_q + 1'b1;
                end else begin
                    ox_d = '0;
                    if (oy_q != OY_MAX) begin
                        oy_d = oy_q + 1'b1;
                    end else begin
                        oy_d = '0;
                        o_d  = (o_q == O_MAX) ? '0 : o_q + 1'b1;
                    end
                end
            end
            StWr: begin
                pk_wr   = 1'b1;
                state_d = fin_q ? StDone : StLoad;
                done_d  = fin_q;
            end
            default: state_d = StIdle;
        endcase
    end

    // Sequencer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            o_q     <= '0;
            oy_q    <= '0;
            ox_q    <= '0;
            py_q    <= 1'b0;
            px_q    <= 1'b0;
            c_q     <= '0;
            ky_q    <= '0;
            kx_q    <= '0;
            acc_q   <= '0;
            max_q   <= '0;
            fin_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            oy_q    <= oy_d;
            ox_q    <= ox_d;
            py_q    <= py_d;
            px_q    <= px_d;
            c_q     <= c_d;
            ky_q    <= ky_d;
            kx_q    <= kx_d;
            acc_q   <= acc_d;
            max_q   <= max_d;
            fin_q   <= fin_d;
            done_q  <= done_d;
        end
    end

    out_packer #(
        .OUT_BASE(OUT_BASE)
    ) u_out_packer (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (pk_clr),
        .push_i     (pk_push),
        .byte_i     ({1'b0, max_q}),
        .last_i     (out_last),
        .wr_i       (pk_wr),
        .flush_o    (pk_flush),
        .temp_addr_o(BRAM_TEMP_ADDR),
        .temp_en_o  (BRAM_TEMP_EN),
        .temp_we_o  (BRAM_TEMP_WE),
        .temp_rst_o (BRAM_TEMP_RST),
        .temp_din_o (BRAM_TEMP_DIN)
    );

    // The TEMP port is write-only; its read data is intentionally ignored.
    logic unused_temp;
    assign unused_temp = ^BRAM_TEMP_DOUT;

endmodule

// File: tb/tb_conv_pool_engine.sv
// Self-checking bench: two engine configurations against a loop-level reference model.
module tb_conv_pool_engine;

    // Config A: pooled, multi-channel, odd conv width, non-zero IF/OUT bases.
    localparam int AH = 6, AW = 7, AC = 2, AO = 3, AK = 3, AP = 1, ASH = 8;
    localparam int AIB = 4, AWB = 0, AOB = 8;
    // Config B: unpooled 4x4, K=2.
    localparam int BH = 4, BW = 4, BC = 1, BO = 1, BK = 2, BP = 0, BSH = 0;
    localparam int BIB = 0, BWB = 8, BOB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_start = 1'b0, b_start = 1'b0, t_clr = 1'b0;
    always #5 clk = ~clk;

    logic        a_busy, a_done, b_busy, b_done;
    logic [31:0] a_if_addr, a_w_addr, a_t_addr, a_if_din, a_w_din, a_t_din;
    logic [31:0] b_if_addr, b_w_addr, b_t_addr, b_if_din, b_w_din, b_t_din;
    logic        a_if_en, a_w_en, a_t_en, a_if_rst, a_w_rst, a_t_rst;
    logic        b_if_en, b_w_en, b_t_en, b_if_rst, b_w_rst, b_t_rst;
    logic [3:0]  a_if_we, a_w_we, a_t_we, b_if_we, b_w_we, b_t_we;
    logic [31:0] a_if_dout = '0, a_w_dout = '0, b_if_dout = '0, b_w_dout = '0;
    logic [31:0] t_dout = '0;

    logic [7:0] a_ifm[256], a_wm[256], a_tm[256];
    logic [7:0] b_ifm[256], b_wm[256], b_tm[256];

    int n_vec = 0;
    int n_err = 0;
    int viol  = 0;

    conv_pool_engine #(
        .IN_H(AH), .IN_W(AW), .IN_CH(AC), .OUT_CH(AO), .K(AK), .POOL(AP), .SHIFT(ASH),
        .IF_BASE(AIB), .W_BASE(AWB), .OUT_BASE(AOB)
    ) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .BRAM_IF_ADDR(a_if_addr), .BRAM_IF_EN(a_if_en), .BRAM_IF_WE(a_if_we),
        .BRAM_IF_RST(a_if_rst), .BRAM_IF_DOUT(a_if_dout), .BRAM_IF_DIN(a_if_din),
        .BRAM_W_ADDR(a_w_addr), .BRAM_W_EN(a_w_en), .BRAM_W_WE(a_w_we),
        .BRAM_W_RST(a_w_rst), .BRAM_W_DOUT(a_w_dout), .BRAM_W_DIN(a_w_din),
        .BRAM_TEMP_ADDR(a_t_addr), .BRAM_TEMP_EN(a_t_en), .BRAM_TEMP_WE(a_t_we),
        .BRAM_TEMP_RST(a_t_rst), .BRAM_TEMP_DOUT(t_dout), .BRAM_TEMP_DIN(a_t_din)
    );

    conv_pool_engine #(
        .IN_H(BH), .IN_W(BW), .IN_CH(BC), .OUT_CH(BO), .K(BK), .POOL(BP), .SHIFT(BSH),
        .IF_BASE(BIB), .W_BASE(BWB), .OUT_BASE(BOB)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .BRAM_IF_ADDR(b_if_addr), .BRAM_IF_EN(b_if_en), .BRAM_IF_WE(b_if_we),
        .BRAM_IF_RST(b_if_rst), .BRAM_IF_DOUT(b_if_dout), .BRAM_IF_DIN(b_if_din),
        .BRAM_W_ADDR(b_w_addr), .BRAM_W_EN(b_w_en), .BRAM_W_WE(b_w_we),
        .BRAM_W_RST(b_w_rst), .BRAM_W_DOUT(b_w_dout), .BRAM_W_DIN(b_w_din),
        .BRAM_TEMP_ADDR(b_t_addr), .BRAM_TEMP_EN(b_t_en), .BRAM_TEMP_WE(b_t_we),
        .BRAM_TEMP_RST(b_t_rst), .BRAM_TEMP_DOUT(t_dout), .BRAM_TEMP_DIN(b_t_din)
    );

    function automatic logic [31:0] rdw(input logic [7:0] m[256], input logic [31:0] a);
        logic [7:0] i;
        i = a[7:0];
        return {m[i + 8'd3], m[i + 8'd2], m[i + 8'd1], m[i]};
    endfunction

    // Synchronous-read BRAM models (one cycle latency).
    always @(posedge clk) begin
        if (a_if_en) a_if_dout <= rdw(a_ifm, a_if_addr);
        if (a_w_en)  a_w_dout  <= rdw(a_wm, a_w_addr);
        if (b_if_en) b_if_dout <= rdw(b_ifm, b_if_addr);
        if (b_w_en)  b_w_dout  <= rdw(b_wm, b_w_addr);
    end

    // TEMP write models; t_clr refills both with a sentinel pattern.
    always @(posedge clk) begin
        if (t_clr) begin
            for (int i = 0; i < 256; i++) begin
                a_tm[i] <= 8'hA5;
                b_tm[i] <= 8'hA5;
            end
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (a_t_en && a_t_we[l]) a_tm[a_t_addr[7:0] + 8'(l)] <= a_t_din[8*l +: 8];
                if (b_t_en && b_t_we[l]) b_tm[b_t_addr[7:0] + 8'(l)] <= b_t_din[8*l +: 8];
            end
        end
    end

    // Port-rule monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (a_if_we != 0 || a_w_we != 0 || a_if_din != 0 || a_w_din != 0) viol++;
        if (b_if_we != 0 || b_w_we != 0 || b_if_din != 0 || b_w_din != 0) viol++;
        if (a_if_rst || a_w_rst || a_t_rst || b_if_rst || b_w_rst || b_t_rst) viol++;
        if (a_if_addr[1:0] != 0 || a_w_addr[1:0] != 0 || a_t_addr[1:0] != 0) viol++;
        if (b_if_addr[1:0] != 0 || b_w_addr[1:0] != 0 || b_t_addr[1:0] != 0) viol++;
        if ((a_t_en && a_t_we != 4'hF) || (b_t_en && b_t_we != 4'hF)) viol++;
        if (!rst && !a_busy && (a_if_en || a_w_en || a_t_en)) viol++;
        if (!rst && !b_busy && (b_if_en || b_w_en || b_t_en)) viol++;
        if ((a_busy && a_done) || (b_busy && b_done)) viol++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: direct loop nest over the layer definition.
    task automatic ref_model(input logic [7:0] ifm[256], input logic [7:0] wm[256],
                             input int h, input int wd, input int ch, input int oc,
                             input int k, input int pool, input int sh, input int ifb,
                             input int wb, output logic [7:0] e[64], output int n,
                             output int cyc);
        int ps, oh, ow, acc, r, m, a, w;
        ps = pool ? 2 : 1;
        oh = (h - k + 1) / ps;
        ow = (wd - k + 1) / ps;
        n = 0;
        for (int i = 0; i < 64; i++) e[i] = 8'h00;
        for (int o = 0; o < oc; o++)
            for (int y = 0; y < oh; y++)
                for (int x = 0; x < ow; x++) begin
                    m = 0;
                    for (int py = 0; py < ps; py++)
                        for (int px = 0; px < ps; px++) begin
                            acc = 0;
                            for (int c = 0; c < ch; c++)
                                for (int ky = 0; ky < k; ky++)
                                    for (int kx = 0; kx < k; kx++) begin
                                        a = $signed(ifm[ifb + c*h*wd + (y*ps+py+ky)*wd
                                                        + x*ps + px + kx]);
                                        w = $signed(wm[wb + ((o*ch + c)*k + ky)*k + kx]);
                                        acc += a * w;
                                    end
                            r = acc >>> sh;
                            r = (r < 0) ? 0 : ((r > 127) ? 127 : r);
                            if (r > m) m = r;
                        end
                    e[n] = 8'(m);
                    n++;
                end
        cyc = n * (ps*ps*(2*ch*k*k + 1) + 1) + (n + 3) / 4;
    endtask

    task automatic cmp_out(input string tag, input logic [7:0] tm[256], input int ob,
                           input logic [7:0] e[64], input int n);
        logic [31:0] ew, gw;
        int nw;
        nw = (n + 3) / 4;
        for (int wi = 0; wi <= nw; wi++) begin
            for (int l = 0; l < 4; l++) begin
                ew[8*l +: 8] = (wi == nw) ? 8'hA5 : ((wi*4 + l < n) ? e[wi*4 + l] : 8'h00);
                gw[8*l +: 8] = tm[ob + wi*4 + l];
            end
            check_eq($sformatf("%s_w%0d", tag, wi), gw, ew);
        end
    endtask

    // Pulse start, optionally re-pulse at cycle 'mid', wait (bounded) for done.
    task automatic run(input bit is_a, input int mid, input string tag, output int cyc);
        t_clr = 1'b1;
        @(posedge clk);
        #1 t_clr = 1'b0;
        if (is_a) a_start = 1'b1; else b_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        b_start = 1'b0;
        check_eq({tag, "_start"}, is_a ? {a_busy, a_done} : {b_busy, b_done}, 32'h2);
        cyc = 0;
        while (!(is_a ? a_done : b_done) && cyc < 6000) begin
            if (cyc == mid) begin
                if (is_a) a_start = 1'b1; else b_start = 1'b1;
            end
            @(posedge clk);
            #1 a_start = 1'b0;
            b_start = 1'b0;
            cyc++;
        end
        check_eq({tag, "_busy_at_done"}, is_a ? a_busy : b_busy, 32'h0);
    endtask

    task automatic do_a(input string tag, input int mid);
        logic [7:0] e[64];
        int n, ecyc, cyc;
        run(1'b1, mid, tag, cyc);
        ref_model(a_ifm, a_wm, AH, AW, AC, AO, AK, AP, ASH, AIB, AWB, e, n, ecyc);
        check_eq({tag, "_latency"}, cyc, ecyc);
        cmp_out(tag, a_tm, AOB, e, n);
    endtask

    task automatic do_b(input string tag);
        logic [7:0] e[64];
        int n, ecyc, cyc;
        run(1'b0, -1, tag, cyc);
        ref_model(b_ifm, b_wm, BH, BW, BC, BO, BK, BP, BSH, BIB, BWB, e, n, ecyc);
        check_eq({tag, "_latency"}, cyc, ecyc);
        cmp_out(tag, b_tm, BOB, e, n);
    endtask

    task automatic fill_a_rand();
        for (int i = 0; i < 256; i++) begin
            a_ifm[i] = 8'($urandom_range(0, 120)) - 8'd20;
            a_wm[i]  = 8'($urandom_range(0, 31)) - 8'd10;
        end
    endtask

    task automatic fill_b(input bit rnd, input logic [7:0] iv, input logic [7:0] wv);
        for (int i = 0; i < 256; i++) begin
            b_ifm[i] = rnd ? 8'($urandom_range(0, 30)) : iv;
            b_wm[i]  = rnd ? 8'($urandom_range(0, 12)) - 8'd4 : wv;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fill_a_rand();
        fill_b(1'b0, 8'd1, 8'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_a", {a_busy, a_done, a_if_en, a_w_en, a_t_en, a_t_we}, 32'h0);
        check_eq("reset_b", {b_busy, b_done, b_if_en, b_w_en, b_t_en, b_t_we}, 32'h0);
        check_eq("reset_addr", a_if_addr | a_w_addr | a_t_addr | a_t_din, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Unpooled directed patterns.
        do_b("b_ones");
        check_eq("b_ones_word2", {b_tm[BOB+11], b_tm[BOB+10], b_tm[BOB+9], b_tm[BOB+8]},
                 32'h0000_0004);
        repeat (5) @(posedge clk);
        #1 check_eq("b_done_held", b_done, 32'h1);
        fill_b(1'b0, 8'd1, 8'hFF);
        do_b("b_relu");
        fill_b(1'b0, 8'd127, 8'd127);
        do_b("b_sat");
        for (int t = 0; t < 3; t++) begin
            fill_b(1'b1, 8'd0, 8'd0);
            do_b($sformatf("b_rnd%0d", t));
        end

        // Pooled random runs, including a start pulse while busy.
        do_a("a_rnd0", -1);
        fill_a_rand();
        do_a("a_midstart", 300);

        // Reset mid-run, then a clean rerun.
        fill_a_rand();
        a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        repeat (500) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_state", {a_busy, a_done, a_if_en, a_w_en, a_t_en, a_t_we}, 32'h0);
        rst = 1'b0;
        do_a("a_after_rst", -1);

        check_eq("port_rules", viol, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
